// File: rtl/cpu_pkg.sv
// Shared CPU definitions: boot vector, code-region encodings, fetch FSM states.
package cpu_pkg;

  // Boot vector lives in BIOS space.
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h4000_0000;

  // pc[31:28] region tags for the two executable regions.
  localparam logic [3:0] REGION_IC   = 4'h1;
  localparam logic [3:0] REGION_BIOS = 4'h4;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  // A fetch address is legal only inside IC/BIOS space and word aligned.
  function automatic logic pc_is_legal(input logic [31:0] pc);
    logic region_ok;
    region_ok = (pc[31:28] == REGION_IC) || (pc[31:28] == REGION_BIOS);
    return region_ok && (pc[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/fetch_pc_legal.sv
// Combinational legality check for a fetch PC; also used by external checkers.
module fetch_pc_legal
  import cpu_pkg::*;
(
  input  logic [31:0] pc,
  output logic        legal
);

  // The middle address bits never influence legality.
  logic unused_mid;
  assign unused_mid = ^pc[27:2];

  // Region tag plus word alignment decide legality.
  always_comb begin
    legal = pc_is_legal(pc);
  end

endmodule

// File: rtl/fetch_pc_gen.sv
// Fetch-stage PC generator: sequential advance, branch/jump redirects with a
// one-entry pending slot for held cycles, F->D register, and illegal-PC parking.
module fetch_pc_gen
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        mem_wait,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc_f,
  output logic [31:0] pc_plus4_f,
  output logic [31:0] pc_d,
  output logic        valid_d,
  output logic        fetch_fault
);

  fetch_state_t state;
  logic         pend_v;
  logic [31:0]  pend_pc;
  logic         hold;
  logic         pc_f_legal;
  logic [31:0]  next_pc;

  assign hold       = stall | mem_wait;
  assign pc_plus4_f = pc_f + 32'd4;

  fetch_pc_legal u_legal (
    .pc    (pc_f),
    .legal (pc_f_legal)
  );

  // Next fetch PC on a free RUN cycle: live redirect, then pending, then +4.
  always_comb begin
    next_pc = pc_plus4_f;
    if (redirect_valid)
      next_pc = redirect_pc;
    else if (pend_v)
      next_pc = pend_pc;
  end

  // Fetch FSM with the PC, pending-redirect and decode registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= BOOT;
      pc_f        <= RESET_PC;
      pc_d        <= 32'd0;
      valid_d     <= 1'b0;
      fetch_fault <= 1'b0;
      pend_v      <= 1'b0;
      pend_pc     <= 32'd0;
    end else begin
      case (state)
        BOOT: begin
          // One settling cycle; an early redirect is kept rather than lost.
          valid_d <= 1'b0;
          state   <= RUN;
          if (redirect_valid) begin
            pend_v  <= 1'b1;
            pend_pc <= redirect_pc;
          end
        end

        RUN: begin
          if (hold) begin
            // Everything freezes; the newest redirect wins the pending slot.
            if (redirect_valid) begin
              pend_v  <= 1'b1;
              pend_pc <= redirect_pc;
            end
          end else if (pc_f_legal) begin
            // Delay slot: the instruction at pc_f is always handed to decode.
            pc_d    <= pc_f;
            valid_d <= 1'b1;
            pc_f    <= next_pc;
            pend_v  <= 1'b0;
          end else begin
            // Illegal fetch: park here; any pending target is abandoned.
            valid_d     <= 1'b0;
            fetch_fault <= 1'b1;
            pend_v      <= 1'b0;
            state       <= HALT;
          end
        end

        HALT: begin
          // Only a fresh redirect releases the front end, even under hold.
          valid_d <= 1'b0;
          pend_v  <= 1'b0;
          if (redirect_valid) begin
            pc_f        <= redirect_pc;
            fetch_fault <= 1'b0;
            state       <= RUN;
          end
        end

        default: state <= BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Directed bench for fetch_pc_gen: boot, stall, held redirects, delay slot,
// fault parking/recovery, PC wrap and asynchronous reset.
module tb_fetch_pc_gen;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        mem_wait = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic [31:0] pc_f, pc_plus4_f, pc_d;
  logic        valid_d, fetch_fault;

  int checks = 0;
  int failures = 0;

  fetch_pc_gen dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .mem_wait       (mem_wait),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .pc_f           (pc_f),
    .pc_plus4_f     (pc_plus4_f),
    .pc_d           (pc_d),
    .valid_d        (valid_d),
    .fetch_fault    (fetch_fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Check the full visible F/D state.
  task automatic chk_fd(input string tag, input logic [31:0] ef, input logic [31:0] ed,
                        input logic ev, input logic eflt);
    chk({tag, ".pc_f"}, pc_f, ef);
    chk({tag, ".pc_d"}, pc_d, ed);
    chk({tag, ".valid_d"}, 32'(valid_d), 32'(ev));
    chk({tag, ".fault"}, 32'(fetch_fault), 32'(eflt));
  endtask

  initial begin
    // Reset state, checked before any clock edge.
    #2 reset = 1'b1;
    #1;
    chk_fd("reset", 32'h4000_0000, 32'h0, 1'b0, 1'b0);
    chk("reset.pend_v", 32'(dut.pend_v), 32'd0);
    step();
    step();
    reset = 1'b0;

    // Boot: one BOOT edge, then sequential fetch.
    step(); chk_fd("boot0", 32'h4000_0000, 32'h0, 1'b0, 1'b0);
    step(); chk_fd("boot1", 32'h4000_0004, 32'h4000_0000, 1'b1, 1'b0);
    chk("boot1.plus4", pc_plus4_f, 32'h4000_0008);
    step(); chk_fd("seq2", 32'h4000_0008, 32'h4000_0004, 1'b1, 1'b0);

    // Stall for 3 cycles freezes F and D.
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(); chk_fd("stall", 32'h4000_0008, 32'h4000_0004, 1'b1, 1'b0);
    end
    stall = 1'b0;
    step(); chk_fd("unstall", 32'h4000_000C, 32'h4000_0008, 1'b1, 1'b0);
    step(); chk_fd("seq4", 32'h4000_0010, 32'h4000_000C, 1'b1, 1'b0);

    // Delay slot: redirect cycle's instruction still reaches decode.
    redirect_valid = 1'b1; redirect_pc = 32'h1000_0000;
    step(); chk_fd("dslot", 32'h1000_0000, 32'h4000_0010, 1'b1, 1'b0);
    redirect_valid = 1'b0;
    step(); chk_fd("tgt0", 32'h1000_0004, 32'h1000_0000, 1'b1, 1'b0);

    // Two redirects under mem_wait: newest wins on release.
    mem_wait = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'h1000_0000;
    step(); chk_fd("hold_rd1", 32'h1000_0004, 32'h1000_0000, 1'b1, 1'b0);
    redirect_pc = 32'h1000_0040;
    step(); chk_fd("hold_rd2", 32'h1000_0004, 32'h1000_0000, 1'b1, 1'b0);
    redirect_valid = 1'b0;
    step(); chk_fd("hold_idle", 32'h1000_0004, 32'h1000_0000, 1'b1, 1'b0);
    chk("hold.pend_v", 32'(dut.pend_v), 32'd1);
    mem_wait = 1'b0;
    step(); chk_fd("release", 32'h1000_0040, 32'h1000_0004, 1'b1, 1'b0);
    chk("release.pend_v", 32'(dut.pend_v), 32'd0);
    step(); chk_fd("after_rel", 32'h1000_0044, 32'h1000_0040, 1'b1, 1'b0);

    // Illegal region: fault, park, then recover under stall.
    redirect_valid = 1'b1; redirect_pc = 32'h2000_0000;
    step(); chk_fd("bad_rd", 32'h2000_0000, 32'h1000_0044, 1'b1, 1'b0);
    redirect_valid = 1'b0;
    step(); chk_fd("fault", 32'h2000_0000, 32'h1000_0044, 1'b0, 1'b1);
    step(); chk_fd("parked", 32'h2000_0000, 32'h1000_0044, 1'b0, 1'b1);
    stall = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'h4000_0100;
    step(); chk_fd("recover", 32'h4000_0100, 32'h1000_0044, 1'b0, 1'b0);
    stall = 1'b0; redirect_valid = 1'b0;
    step(); chk_fd("resume", 32'h4000_0104, 32'h4000_0100, 1'b1, 1'b0);

    // Misaligned target faults the same way.
    redirect_valid = 1'b1; redirect_pc = 32'h1000_0002;
    step(); chk_fd("mis_rd", 32'h1000_0002, 32'h4000_0104, 1'b1, 1'b0);
    redirect_valid = 1'b0;
    step(); chk_fd("mis_fault", 32'h1000_0002, 32'h4000_0104, 1'b0, 1'b1);
    redirect_valid = 1'b1; redirect_pc = 32'h1000_0100;
    step(); chk_fd("mis_rec", 32'h1000_0100, 32'h4000_0104, 1'b0, 1'b0);
    redirect_valid = 1'b0;
    step(); chk_fd("mis_res", 32'h1000_0104, 32'h1000_0100, 1'b1, 1'b0);

    // Wrap: pc_plus4_f of FFFF_FFFC is 0; that PC itself is illegal.
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step(); chk("wrap.pc_f", pc_f, 32'hFFFF_FFFC);
    chk("wrap.plus4", pc_plus4_f, 32'h0);
    redirect_valid = 1'b0;
    step(); chk_fd("wrap_fault", 32'hFFFF_FFFC, 32'h1000_0104, 1'b0, 1'b1);
    redirect_valid = 1'b1; redirect_pc = 32'h4000_0200;
    step(); chk_fd("wrap_rec", 32'h4000_0200, 32'h1000_0104, 1'b0, 1'b0);
    redirect_valid = 1'b0;
    step(); chk_fd("wrap_res", 32'h4000_0204, 32'h4000_0200, 1'b1, 1'b0);

    // Async reset mid-stall with a pending redirect.
    stall = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'h1000_0000;
    step(); chk("areset.pre_pend", 32'(dut.pend_v), 32'd1);
    redirect_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk_fd("areset", 32'h4000_0000, 32'h0, 1'b0, 1'b0);
    chk("areset.pend_v", 32'(dut.pend_v), 32'd0);
    chk("areset.state", 32'(dut.state), 32'(BOOT));
    step();
    reset = 1'b0;
    step(); chk_fd("reboot0", 32'h4000_0000, 32'h0, 1'b0, 1'b0);
    stall = 1'b0;
    step(); chk_fd("reboot1", 32'h4000_0004, 32'h4000_0000, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety net against a stuck run.
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
